frame_parser_crc16: RTL

- Parametrised successor of the 16-bit frame receiver.
- Hunts a two-word header, captures a channel word, and buffers up to MAX_WORDS payload words followed by a CRC word and a two-word tail.
- Checks a true CRC-16/CCITT over the payload, then writes one packed record to the downstream channel FIFO.
- Adds input qualification, FIFO backpressure handling, length checking and distinct error pulses.

---
 rtl/frame_pkg.sv | 31 +++
 rtl/frame_delay_line.sv | 46 ++++
 rtl/frame_parser_crc16.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Shared types, constants and the CRC-16/CCITT word update for the frame parser.
package frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR2 = 2'd1,
        CHAN = 2'd2,
        BODY = 2'd3
    } state_t;

    localparam logic [15:0] HDR_WORD_DEF  = 16'hE0E0;
    localparam logic [15:0] TAIL_WORD_DEF = 16'h0E0E;
    localparam logic [15:0] CRC16_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;

    // One 16-bit word folded into the CRC, MSB first, no reflection.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc,
                                               input logic [15:0] word);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ word[i]) begin
                c = {c[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_delay_line.sv
// Three-entry word delay line. Holds back the CRC word and the first tail
// word so that payload is only committed once it is known not to be trailer.
module frame_delay_line
    import frame_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] word0_o,      // newest entry
    output logic [DATA_W-1:0] word1_o,      // entry in front of the newest
    output logic [DATA_W-1:0] eject_data_o, // oldest entry
    output logic [1:0]        count_o,
    output logic              eject_o
);

    logic [DATA_W-1:0] line_q [3];
    logic [1:0]        count_q;

    // Shift on push; clear wipes contents and count at the start of a frame.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int i = 0; i < 3; i++) begin
                line_q[i] <= '0;
            end
            count_q <= 2'd0;
        end else if (push_i) begin
            line_q[0] <= data_i;
            line_q[1] <= line_q[0];
            line_q[2] <= line_q[1];
            if (count_q != 2'd3) begin
                count_q <= count_q + 2'd1;
            end
        end
    end

    assign word0_o      = line_q[0];
    assign word1_o      = line_q[1];
    assign eject_data_o = line_q[2];
    assign count_o      = count_q;
    assign eject_o      = push_i && (count_q == 2'd3);

endmodule

// File: rtl/frame_parser_crc16.sv
// Frame receiver: header hunt, channel capture, payload buffering with a
// CRC-16/CCITT check, length checking and one packed record per good frame.
module frame_parser_crc16
    import frame_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter int          MAX_WORDS = 8,
    parameter int          CH_W      = 8,
    parameter logic [15:0] HDR_WORD  = HDR_WORD_DEF,
    parameter logic [15:0] TAIL_WORD = TAIL_WORD_DEF,
    parameter logic [15:0] CRC_INIT  = CRC16_INIT,
    localparam int         LEN_W     = $clog2(MAX_WORDS + 1),
    localparam int         OUT_W     = LEN_W + CH_W + MAX_WORDS * DATA_W
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              fifo_full,
    output logic [OUT_W-1:0]  fifo_w_data,
    output logic              fifo_w_enable,
    output logic              crc_err,
    output logic              len_err,
    output logic              ovf_err,
    output logic              busy
);

    // Body word counter must reach MAX_WORDS+3 and still form body_cnt+1.
    localparam int CNT_W = $clog2(MAX_WORDS + 5);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_WORDS + 3);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(MAX_WORDS + 2);

    state_t              state_q;
    logic [CH_W-1:0]     chan_q;
    logic [15:0]         crc_q;
    logic [CNT_W-1:0]    body_cnt_q;
    logic [DATA_W-1:0]   payload_q [MAX_WORDS];
    logic [OUT_W-1:0]    fifo_w_data_q;
    logic                fifo_w_enable_q;
    logic                crc_err_q;
    logic                len_err_q;
    logic                ovf_err_q;

    logic                dl_clear;
    logic                dl_push;
    logic [DATA_W-1:0]   dl_w0;
    logic [DATA_W-1:0]   dl_w1;
    logic [DATA_W-1:0]   dl_eject_data;
    logic [1:0]          dl_cnt;
    logic                dl_eject;

    logic [15:0]         crc_d;
    logic [CNT_W-1:0]    slot_idx;
    logic [CNT_W-1:0]    len_full;
    logic                tail_hit;
    logic                body_accept;
    logic [DATA_W-1:0]   slot_d [MAX_WORDS];
    logic [MAX_WORDS*DATA_W-1:0] payload_packed;
    logic [OUT_W-1:0]    record_d;

    assign body_accept = data_valid && (state_q == BODY);
    assign dl_push     = body_accept;
    assign dl_clear    = data_valid && (state_q == CHAN);

    frame_delay_line #(
        .DATA_W (DATA_W)
    ) u_delay (
        .clk_i        (clk_in),
        .rst_i        (rst),
        .clear_i      (dl_clear),
        .push_i       (dl_push),
        .data_i       (data_in),
        .word0_o      (dl_w0),
        .word1_o      (dl_w1),
        .eject_data_o (dl_eject_data),
        .count_o      (dl_cnt),
        .eject_o      (dl_eject)
    );

    // Next CRC, payload slot and tail detection for the word being accepted.
    always_comb begin
        crc_d    = dl_eject ? crc16_word(crc_q, dl_eject_data[15:0]) : crc_q;
        slot_idx = body_cnt_q - CNT_W'(3);
        len_full = body_cnt_q - CNT_W'(2);
        tail_hit = (dl_cnt != 2'd0) && (dl_w0 == TAIL_WORD) && (data_in == TAIL_WORD);
    end

    // Payload buffer with the ejected word merged in, so the record built at
    // the tail edge already contains the last payload word.
    generate
        for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_slot
            assign slot_d[gi] = (dl_eject && (slot_idx == CNT_W'(gi))) ? dl_eject_data
                                                                        : payload_q[gi];
            assign payload_packed[(MAX_WORDS-gi)*DATA_W-1 -: DATA_W] = slot_d[gi];

            // Slot storage: cleared on reset and at channel capture.
            always_ff @(posedge clk_in) begin
                if (rst || dl_clear) begin
                    payload_q[gi] <= '0;
                end else if (body_accept) begin
                    payload_q[gi] <= slot_d[gi];
                end
            end
        end
    endgenerate

    assign record_d = {LEN_W'(len_full), chan_q, payload_packed};

    // Frame state machine with registered result pulses.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q         <= IDLE;
            chan_q          <= '0;
            crc_q           <= '0;
            body_cnt_q      <= '0;
            fifo_w_data_q   <= '0;
            fifo_w_enable_q <= 1'b0;
            crc_err_q       <= 1'b0;
            len_err_q       <= 1'b0;
            ovf_err_q       <= 1'b0;
        end else begin
            fifo_w_enable_q <= 1'b0;
            crc_err_q       <= 1'b0;
            len_err_q       <= 1'b0;
            ovf_err_q       <= 1'b0;
            if (data_valid) begin
                case (state_q)
                    IDLE: begin
                        if (data_in == HDR_WORD) begin
                            state_q <= HDR2;
                        end
                    end
                    HDR2: begin
                        state_q <= (data_in == HDR_WORD) ? CHAN : IDLE;
                    end
                    CHAN: begin
                        chan_q     <= data_in[CH_W-1:0];
                        crc_q      <= CRC_INIT;
                        body_cnt_q <= '0;
                        state_q    <= BODY;
                    end
                    BODY: begin
                        crc_q <= crc_d;
                        if (body_cnt_q != CNT_SAT) begin
                            body_cnt_q <= body_cnt_q + CNT_W'(1);
                        end
                        if (tail_hit) begin
                            state_q <= IDLE;
                            // Fewer than one payload word in front of CRC + tail.
                            if (body_cnt_q < CNT_W'(3)) begin
                                len_err_q <= 1'b1;
                            end else if (crc_d != dl_w1[15:0]) begin
                                crc_err_q <= 1'b1;
                            end else if (fifo_full) begin
                                ovf_err_q <= 1'b1;
                            end else begin
                                fifo_w_enable_q <= 1'b1;
                                fifo_w_data_q   <= record_d;
                            end
                        end else if (body_cnt_q >= CNT_OVER) begin
                            len_err_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign fifo_w_data   = fifo_w_data_q;
    assign fifo_w_enable = fifo_w_enable_q;
    assign crc_err       = crc_err_q;
    assign len_err       = len_err_q;
    assign ovf_err       = ovf_err_q;
    assign busy          = (state_q != IDLE);

endmodule
